// File: rtl/ifu_mem_fetch.sv
// ifu_mem_fetch: one-outstanding instruction fetch over a req/gnt/rvalid port, with a valid/ready output and fault codes
module ifu_mem_fetch #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [DATA_W-1:0] pc,
    output logic              busy,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_err,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] inst,
    output logic [DATA_W-1:0] inst_pc,
    output logic [1:0]        fault
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, VALID} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t     state;
    logic [7:0] cnt;
    logic       accept;
    assign accept   = fetch_req && (state == IDLE || (state == VALID && ready));
    assign busy     = state != IDLE;
    assign imem_req = state == REQ;
    assign valid    = state == VALID;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            imem_addr <= '0;
            inst_pc   <= '0;
            inst      <= '0;
            fault     <= 2'd0;
        end else if (accept) begin
            imem_addr <= pc;
            inst_pc   <= pc;
            inst      <= '0;
            state     <= pc[1:0] != 2'b00 ? VALID : REQ;
            fault     <= pc[1:0] != 2'b00 ? 2'd3 : 2'd0;
        end else begin
            case (state)
                REQ: if (imem_gnt) begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                // a response arriving on the timeout cycle takes priority over the timeout
                WAIT: if (imem_rvalid) begin
                    inst  <= imem_err ? '0 : imem_rdata;
                    fault <= imem_err ? 2'd1 : 2'd0;
                    state <= VALID;
                end else if (cnt == LAST) begin
                    inst  <= '0;
                    fault <= 2'd2;
                    state <= VALID;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                VALID: if (ready) state <= IDLE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_mem_fetch.sv
// tb_ifu_mem_fetch: per-cycle directed vectors for ifu_mem_fetch, built with TIMEOUT=4
module tb_ifu_mem_fetch;
    logic        clk = 0, rst = 0, fetch_req = 0, imem_gnt = 0, imem_rvalid = 0, imem_err = 0, ready = 0;
    logic [31:0] pc = 0, imem_rdata = 0;
    logic        busy, imem_req, valid;
    logic [31:0] imem_addr, inst, inst_pc;
    logic [1:0]  fault;
    int          nvec = 0, nmis = 0;

    ifu_mem_fetch #(.DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc(pc), .busy(busy),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .valid(valid), .ready(ready), .inst(inst), .inst_pc(inst_pc), .fault(fault)
    );

    always #5 clk = ~clk;

    // ic = {rst, fetch_req, gnt, rvalid, err, ready}; oc = {valid, busy, imem_req, check_all}
    typedef struct {
        logic [5:0]  ic;
        logic [31:0] pc, rdata;
        logic [3:0]  oc;
        logic [31:0] addr, inst, ipc;
        logic [1:0]  fault;
    } vec_t;

    function automatic vec_t mk(logic [5:0] ic, logic [31:0] p, logic [31:0] d, logic [3:0] oc,
                                logic [31:0] a, logic [31:0] i, logic [31:0] ip, logic [1:0] f);
        vec_t v;
        v.ic = ic; v.pc = p; v.rdata = d; v.oc = oc;
        v.addr = a; v.inst = i; v.ipc = ip; v.fault = f;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        logic ev, eb, eq, all, bad;
        @(negedge clk);
        {rst, fetch_req, imem_gnt, imem_rvalid, imem_err, ready} = v.ic;
        pc = v.pc;
        imem_rdata = v.rdata;
        @(posedge clk);
        #1;
        {ev, eb, eq, all} = v.oc;
        nvec++;
        bad = valid !== ev || busy !== eb || imem_req !== eq
           || ((all || eq) && imem_addr !== v.addr)
           || ((all || ev) && (inst !== v.inst || inst_pc !== v.ipc || fault !== v.fault));
        if (bad) begin
            nmis++;
            $display("FAIL %s: got valid=%b busy=%b req=%b addr=%h inst=%h pc=%h fault=%0d; expected valid=%b busy=%b req=%b addr=%h inst=%h pc=%h fault=%0d",
                     nm, valid, busy, imem_req, imem_addr, inst, inst_pc, fault,
                     ev, eb, eq, v.addr, v.inst, v.ipc, v.fault);
        end
    endtask

    localparam logic [31:0] Z = 32'h0;
    vec_t tbl[19];

    initial begin
        tbl[0]  = mk(6'b000000, Z, Z, 4'b0001, Z, Z, Z, 2'd0);
        tbl[1]  = mk(6'b011101, 32'h8000_0000, 32'hffff_ffff, 4'b0001, Z, Z, Z, 2'd0);
        tbl[2]  = mk(6'b100100, Z, 32'h5555_5555, 4'b0000, Z, Z, Z, 2'd0);
        tbl[3]  = mk(6'b110000, 32'h8000_0000, Z, 4'b0110, 32'h8000_0000, Z, Z, 2'd0);
        tbl[4]  = mk(6'b101000, Z, Z, 4'b0100, Z, Z, Z, 2'd0);
        tbl[5]  = mk(6'b100100, Z, 32'h0010_0073, 4'b1100, Z, 32'h0010_0073, 32'h8000_0000, 2'd0);
        tbl[6]  = mk(6'b100001, Z, Z, 4'b0000, Z, Z, Z, 2'd0);
        tbl[7]  = mk(6'b110000, 32'h8000_0010, Z, 4'b0110, 32'h8000_0010, Z, Z, 2'd0);
        tbl[8]  = mk(6'b101000, Z, Z, 4'b0100, Z, Z, Z, 2'd0);
        tbl[9]  = mk(6'b100110, Z, 32'hdead_beef, 4'b1100, Z, Z, 32'h8000_0010, 2'd1);
        tbl[10] = mk(6'b100001, Z, Z, 4'b0000, Z, Z, Z, 2'd0);
        tbl[11] = mk(6'b111000, 32'h8000_0002, Z, 4'b1100, Z, Z, 32'h8000_0002, 2'd3);
        tbl[12] = mk(6'b101100, Z, 32'h7777_7777, 4'b1100, Z, Z, 32'h8000_0002, 2'd3);
        tbl[13] = mk(6'b110001, 32'h8000_0003, Z, 4'b1100, Z, Z, 32'h8000_0003, 2'd3);
        tbl[14] = mk(6'b110001, 32'h8000_0020, Z, 4'b0110, 32'h8000_0020, Z, Z, 2'd0);
        tbl[15] = mk(6'b101000, Z, Z, 4'b0100, Z, Z, Z, 2'd0);
        tbl[16] = mk(6'b110000, 32'h9000_0000, Z, 4'b0100, Z, Z, Z, 2'd0);
        tbl[17] = mk(6'b100100, Z, 32'h1111_2222, 4'b1100, Z, 32'h1111_2222, 32'h8000_0020, 2'd0);
        tbl[18] = mk(6'b100001, Z, Z, 4'b0000, Z, Z, Z, 2'd0);
        for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // gnt stalled 3 cycles, rvalid on the last WAIT cycle, ready held low 5 cycles
        apply(mk(6'b110000, 32'h8000_0040, Z, 4'b0110, 32'h8000_0040, Z, Z, 2'd0), "stall_req");
        for (int i = 0; i < 3; i++)
            apply(mk(6'b110100, 32'h9999_0000, 32'h0bad_0bad, 4'b0110, 32'h8000_0040, Z, Z, 2'd0), "stall_nognt");
        apply(mk(6'b101000, Z, Z, 4'b0100, Z, Z, Z, 2'd0), "stall_gnt");
        for (int i = 0; i < 3; i++) apply(mk(6'b100000, Z, Z, 4'b0100, Z, Z, Z, 2'd0), "stall_wait");
        apply(mk(6'b100100, Z, 32'hcafe_f00d, 4'b1100, Z, 32'hcafe_f00d, 32'h8000_0040, 2'd0), "stall_last_rvalid");
        for (int i = 0; i < 5; i++)
            apply(mk(6'b100100, Z, 32'h1234_5678, 4'b1100, Z, 32'hcafe_f00d, 32'h8000_0040, 2'd0), "stall_hold");
        apply(mk(6'b100001, Z, Z, 4'b0000, Z, Z, Z, 2'd0), "stall_handoff");
        apply(mk(6'b100001, Z, Z, 4'b0000, Z, Z, Z, 2'd0), "stall_single");

        // timeout after 4 WAIT cycles, then a late rvalid must be dropped
        apply(mk(6'b110000, 32'h8000_0080, Z, 4'b0110, 32'h8000_0080, Z, Z, 2'd0), "to_req");
        apply(mk(6'b101000, Z, Z, 4'b0100, Z, Z, Z, 2'd0), "to_gnt");
        for (int i = 0; i < 3; i++) apply(mk(6'b100000, Z, Z, 4'b0100, Z, Z, Z, 2'd0), "to_wait");
        apply(mk(6'b100000, Z, Z, 4'b1100, Z, Z, 32'h8000_0080, 2'd2), "to_fault");
        apply(mk(6'b100100, Z, 32'h0000_1234, 4'b1100, Z, Z, 32'h8000_0080, 2'd2), "to_late_rvalid");
        apply(mk(6'b100001, Z, Z, 4'b0000, Z, Z, Z, 2'd0), "to_handoff");

        // reset in WAIT abandons the fetch; a following fetch completes normally
        apply(mk(6'b110000, 32'h8000_00c0, Z, 4'b0110, 32'h8000_00c0, Z, Z, 2'd0), "rst_req");
        apply(mk(6'b101000, Z, Z, 4'b0100, Z, Z, Z, 2'd0), "rst_gnt");
        apply(mk(6'b000101, Z, 32'h4444_4444, 4'b0001, Z, Z, Z, 2'd0), "rst_in_wait");
        apply(mk(6'b100000, Z, Z, 4'b0000, Z, Z, Z, 2'd0), "rst_release");
        apply(mk(6'b110000, 32'h8000_0100, Z, 4'b0110, 32'h8000_0100, Z, Z, 2'd0), "rst_new_req");
        apply(mk(6'b101000, Z, Z, 4'b0100, Z, Z, Z, 2'd0), "rst_new_gnt");
        apply(mk(6'b100100, Z, 32'h0000_0013, 4'b1100, Z, 32'h0000_0013, 32'h8000_0100, 2'd0), "rst_new_data");
        apply(mk(6'b100001, Z, Z, 4'b0000, Z, Z, Z, 2'd0), "rst_new_handoff");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
